// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter and its producer queues.
package cdb_pkg;

  localparam int unsigned CDB_NUM_REQ    = 3;
  localparam int unsigned CDB_TAG_BITS   = 5;
  localparam int unsigned CDB_DATA_WIDTH = 32;
  localparam int unsigned CDB_Q_DEPTH    = 2;

  typedef struct packed {
    logic [CDB_TAG_BITS-1:0]   tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_entry_t;

  typedef enum logic [1:0] {
    CDB_SRC_ALU    = 2'd0,
    CDB_SRC_LOAD   = 2'd1,
    CDB_SRC_BRANCH = 2'd2
  } cdb_src_e;

  // Modulo-n add used to rotate and un-rotate round-robin indices.
  function automatic int rr_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/cdb_req_queue.sv
// Small per-producer FIFO holding tagged results until the CDB grants them.
module cdb_req_queue #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q;
  logic                        do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
  a_count_bound:  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB among queued result producers.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = CDB_NUM_REQ,
  parameter int unsigned TAG_BITS   = CDB_TAG_BITS,
  parameter int unsigned DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int unsigned Q_DEPTH    = CDB_Q_DEPTH,
  localparam int unsigned SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][TAG_BITS-1:0]     req_tag,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 cdb_stall,
  output logic                                 cdb_valid,
  output logic [TAG_BITS-1:0]                  cdb_tag,
  output logic [DATA_WIDTH-1:0]                cdb_data,
  output logic [SRC_W-1:0]                     cdb_src
);

  localparam int unsigned ENTRY_W = TAG_BITS + DATA_WIDTH;

  logic [NUM_REQ-1:0]              cand, rot, push, pop, full, empty;
  logic [NUM_REQ-1:0][ENTRY_W-1:0] heads;
  logic [ENTRY_W-1:0]              win;
  logic [SRC_W-1:0]                rr_ptr_q, grant_idx;
  logic                            grant_valid, load;
  int                              grant_off;

  assign load      = !cdb_valid || !cdb_stall;
  assign req_ready = ~full;
  assign win       = heads[grant_idx];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_q
    assign cand[i] = !empty[i];
    assign push[i] = req_valid[i] && !full[i] && !flush;
    assign pop[i]  = load && grant_valid && !flush && (grant_idx == SRC_W'(i));

    cdb_req_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (Q_DEPTH)
    ) u_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push[i]),
      .pop       (pop[i]),
      .push_data ({req_tag[i], req_data[i]}),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (heads[i])
    );
  end

  // Rotate candidates so rr_ptr sits at bit 0, take the lowest set bit, then un-rotate.
  always_comb begin
    rot       = '0;
    grant_off = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      rot[j] = cand[rr_add(32'(rr_ptr_q), j, NUM_REQ)];
    end
    grant_valid = |rot;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) grant_off = j;
    end
    grant_idx = SRC_W'(rr_add(32'(rr_ptr_q), grant_off, NUM_REQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      rr_ptr_q  <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (load) begin
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_tag  <= win[ENTRY_W-1 -: TAG_BITS];
        cdb_data <= win[DATA_WIDTH-1:0];
        cdb_src  <= grant_idx;
        rr_ptr_q <= SRC_W'(rr_add(32'(grant_idx), 1, NUM_REQ));
      end
    end
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (cdb_valid && cdb_stall && !flush) |=> (cdb_valid && $stable({cdb_tag, cdb_data, cdb_src})));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, latency, round-robin, stall, flush, full.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic              clk, rst_n, flush, cdb_stall;
  logic [2:0]        req_valid, req_ready;
  logic [2:0][4:0]   req_tag;
  logic [2:0][31:0]  req_data;
  logic              cdb_valid;
  logic [4:0]        cdb_tag;
  logic [31:0]       cdb_data;
  logic [1:0]        cdb_src;

  int n_vec  = 0;
  int n_miss = 0;

  cdb_arbiter u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_stall (cdb_stall),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] dat_of(input logic [4:0] t);
    return 32'h1000_0000 | 32'(t);
  endfunction

  task automatic chk_bus(input string name, input logic [4:0] t, input logic [1:0] s);
    chk({name, ".valid"}, 32'(cdb_valid), 32'd1);
    chk({name, ".tag"},   32'(cdb_tag),   32'(t));
    chk({name, ".src"},   32'(cdb_src),   32'(s));
    chk({name, ".data"},  cdb_data,       dat_of(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] t);
    req_tag[i]  = t;
    req_data[i] = dat_of(t);
  endtask

  task automatic do_reset();
    flush = 0; req_valid = '0; cdb_stall = 0;
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; flush = 0; cdb_stall = 0; req_valid = '0; req_tag = '0; req_data = '0;

    // Reset / idle
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst.valid", 32'(cdb_valid), 32'd0);
      chk("rst.ready", 32'(req_ready), 32'h7);
    end
    rst_n = 1;
    step();
    chk("idle.valid", 32'(cdb_valid), 32'd0);
    chk("idle.ready", 32'(req_ready), 32'h7);

    // Single push: on the bus two edges after the handshake
    req_tag[0] = 5'd5; req_data[0] = 32'hDEAD_BEEF; req_valid = 3'b001;
    step();
    req_valid = '0;
    chk("single.t0.valid", 32'(cdb_valid), 32'd0);
    step();
    chk("single.valid", 32'(cdb_valid), 32'd1);
    chk("single.tag", 32'(cdb_tag), 32'd5);
    chk("single.src", 32'(cdb_src), 32'(CDB_SRC_ALU));
    chk("single.data", cdb_data, 32'hDEAD_BEEF);
    step();
    chk("single.t2.valid", 32'(cdb_valid), 32'd0);

    // Round-robin with all producers pushing every cycle
    do_reset();
    set_req(0, 5'd1); set_req(1, 5'd2); set_req(2, 5'd3); req_valid = 3'b111;
    step();
    chk("rr.first.valid", 32'(cdb_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_bus("rr.grant", 5'(k % 3 + 1), 2'(k % 3));
      chk("rr.ready", 32'(req_ready), 32'(3'b001 << (k % 3)));
    end
    req_valid = '0;

    // Stall: bus holds while LOAD queue fills
    do_reset();
    set_req(0, 5'd7); req_valid = 3'b001;
    step();
    set_req(1, 5'd8); req_valid = 3'b010; cdb_stall = 1;
    step();
    chk_bus("stall.load", 5'd7, CDB_SRC_ALU);
    set_req(1, 5'd9); set_req(2, 5'd11); req_valid = 3'b110;
    step();
    chk_bus("stall.hold", 5'd7, CDB_SRC_ALU);
    chk("stall.ready", 32'(req_ready), 32'h5);
    set_req(1, 5'd10); req_valid = 3'b010;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_bus("stall.hold", 5'd7, CDB_SRC_ALU);
      chk("stall.ready", 32'(req_ready), 32'h5);
    end
    cdb_stall = 0; req_valid = '0;
    step();
    chk_bus("stall.rel1", 5'd8, CDB_SRC_LOAD);
    step();
    chk_bus("stall.rel2", 5'd11, CDB_SRC_BRANCH);
    step();
    chk_bus("stall.rel3", 5'd9, CDB_SRC_LOAD);
    step();
    chk("stall.drained", 32'(cdb_valid), 32'd0);

    // Flush with full queues and a valid broadcast under stall
    do_reset();
    set_req(0, 5'd1); set_req(1, 5'd2); set_req(2, 5'd3); req_valid = 3'b111;
    step();
    set_req(0, 5'd4); set_req(1, 5'd5); set_req(2, 5'd6); cdb_stall = 1;
    step();
    chk_bus("flush.pre", 5'd1, CDB_SRC_ALU);
    set_req(0, 5'd7); req_valid = 3'b001;
    step();
    chk("flush.pre.ready", 32'(req_ready), 32'h0);
    flush = 1; set_req(0, 5'd20); set_req(1, 5'd21); set_req(2, 5'd22); req_valid = 3'b111;
    step();
    chk("flush.valid", 32'(cdb_valid), 32'd0);
    chk("flush.ready", 32'(req_ready), 32'h7);
    flush = 0; req_valid = '0; cdb_stall = 0;
    step();
    chk("flush.empty", 32'(cdb_valid), 32'd0);
    set_req(1, 5'd30); req_valid = 3'b010; flush = 1;
    step();
    flush = 0; req_valid = '0;
    step();
    chk("flush.dropped", 32'(cdb_valid), 32'd0);
    // rr_ptr was 1 before the flush and must still be 1
    set_req(0, 5'd1); set_req(1, 5'd2); set_req(2, 5'd3); req_valid = 3'b111;
    step();
    req_valid = '0;
    step();
    chk_bus("flush.rr1", 5'd2, CDB_SRC_LOAD);
    step();
    chk_bus("flush.rr2", 5'd3, CDB_SRC_BRANCH);
    step();
    chk_bus("flush.rr3", 5'd1, CDB_SRC_ALU);
    step();
    chk("flush.rr.end", 32'(cdb_valid), 32'd0);

    // Full boundary: pop and push on a full queue in the same cycle
    do_reset();
    set_req(0, 5'd1); set_req(2, 5'd12); req_valid = 3'b101;
    step();
    set_req(2, 5'd13); req_valid = 3'b100; cdb_stall = 1;
    step();
    chk_bus("full.alu", 5'd1, CDB_SRC_ALU);
    chk("full.ready", 32'(req_ready), 32'h3);
    cdb_stall = 0; set_req(2, 5'd14); req_valid = 3'b100;
    step();
    chk_bus("full.pop", 5'd12, CDB_SRC_BRANCH);
    chk("full.after.ready", 32'(req_ready), 32'h7);
    req_valid = '0;
    step();
    chk_bus("full.next", 5'd13, CDB_SRC_BRANCH);
    step();
    chk("full.refused", 32'(cdb_valid), 32'd0);

    // Async reset in the middle of a stall
    set_req(0, 5'd9); req_valid = 3'b001;
    step();
    req_valid = '0; cdb_stall = 1;
    step();
    chk_bus("areset.pre", 5'd9, CDB_SRC_ALU);
    step();
    chk_bus("areset.hold", 5'd9, CDB_SRC_ALU);
    #2 rst_n = 0;
    #1;
    chk("areset.valid", 32'(cdb_valid), 32'd0);
    chk("areset.tag", 32'(cdb_tag), 32'd0);
    chk("areset.ready", 32'(req_ready), 32'h7);
    step();
    rst_n = 1; cdb_stall = 0;
    step();
    chk("areset.after", 32'(cdb_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
